// File: rtl/gf2_polydiv58.sv
// gf2_polydiv58: bit-serial GF(2) long division of a 115-bit dividend by a 58-bit divisor.
// Define GF2DIV_QUOTIENT_EN to build the quotient register; otherwise quotient reads 0 (reduction only).
module gf2_polydiv58 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [114:0] dividend,
  input  logic [57:0]  divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [114:0] quotient,
  output logic [56:0]  remainder,
  output logic         div_by_zero
);

  localparam int N  = 58;
  localparam int M  = 2 * N - 1;
  localparam int RW = N - 1;

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   r_q, r_d;
  logic [N-1:0]   d_q, d_d;
  logic [5:0]     s_q, s_d;
  logic [6:0]     p_q, p_d;
  logic [6:0]     dpos_q, dpos_d;
  logic [M-1:0]   align;
  logic           load_out;
  logic           dz_d;
  logic [RW-1:0]  rem_q;
  logic           dz_q;
`ifdef GF2DIV_QUOTIENT_EN
  logic [M-1:0]   q_q, q_d;
  logic [M-1:0]   quo_q;
`endif

  // Normalized divisor with its leading 1 lined up under R[p]; the s zero low bits of the
  // normalized divisor are exactly the ones that fall off the bottom when p < 57.
  assign align = {d_q, {(M - N){1'b0}}} >> (7'd114 - p_q);

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    s_d      = s_q;
    p_d      = p_q;
    dpos_d   = dpos_q;
    load_out = 1'b0;
    dz_d     = 1'b0;
`ifdef GF2DIV_QUOTIENT_EN
    q_d      = q_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = dividend;
          d_d     = divisor;
          s_d     = '0;
`ifdef GF2DIV_QUOTIENT_EN
          q_d     = '0;
`endif
          state_d = NORM;
        end
      end
      NORM: begin
        // A zero divisor takes one harmless shift before it is flagged, giving the A+2 result edge.
        if (d_q == '0 && s_q != '0) begin
          r_d      = '0;
          dz_d     = 1'b1;
          load_out = 1'b1;
`ifdef GF2DIV_QUOTIENT_EN
          q_d      = '0;
`endif
          state_d  = DONE;
        end else if (d_q[N-1]) begin
          dpos_d  = 7'd57 - {1'b0, s_q};
          p_d     = 7'd114;
          state_d = DIV;
        end else begin
          d_d = d_q << 1;
          s_d = s_q + 6'd1;
        end
      end
      DIV: begin
        if (r_q[p_q]) begin
          r_d = r_q ^ align;
`ifdef GF2DIV_QUOTIENT_EN
          q_d = q_q | (M'(1) << (p_q - dpos_q));
`endif
        end
        p_d = p_q - 7'd1;
        if (p_q == dpos_q) begin
          load_out = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      dpos_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      s_q     <= s_d;
      p_q     <= p_d;
      dpos_q  <= dpos_d;
      if (load_out) begin
        rem_q <= r_d[RW-1:0];
        dz_q  <= dz_d;
      end
    end
  end

`ifdef GF2DIV_QUOTIENT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      quo_q <= '0;
    end else begin
      q_q <= q_d;
      if (load_out) quo_q <= q_d;
    end
  end

  assign quotient = quo_q;
`else
  assign quotient = '0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_gf2_polydiv58.sv
// Self-checking bench for gf2_polydiv58: degree-based long-division model, latency model,
// multiply-back identity, backpressure and mid-operation reset.
module tb_gf2_polydiv58;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [114:0] dividend = '0;
  logic [57:0]  divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [114:0] quotient;
  logic [56:0]  remainder;

  int n_checks = 0;
  int n_fail   = 0;

  logic [114:0] exp_q  = '0;
  logic [114:0] exp_r  = '0;
  logic         exp_dz = 1'b0;

`ifdef GF2DIV_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  always #5 clk = ~clk;

  gf2_polydiv58 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int deg_of(input logic [57:0] b);
    int dg = -1;
    for (int i = 0; i < 58; i++) if (b[i]) dg = i;
    return dg;
  endfunction

  // Textbook long division on polynomial degrees; no normalization or pointers.
  function automatic void ref_div(input logic [114:0] a, input logic [57:0] b,
                                  output logic [114:0] q, output logic [114:0] r,
                                  output logic dz);
    int db;
    q = '0; r = a; dz = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
      r  = '0;
      return;
    end
    db = deg_of(b);
    for (int i = 114; i >= db; i--) begin
      if (r[i]) begin
        r = r ^ (115'(b) << (i - db));
        q[i - db] = 1'b1;
      end
    end
  endfunction

  function automatic int ref_latency(input logic [57:0] b);
    if (b == '0) return 2;
    return 2 * (57 - deg_of(b)) + 59;
  endfunction

  function automatic logic [114:0] clmul(input logic [114:0] q, input logic [57:0] b);
    logic [114:0] acc = '0;
    for (int i = 0; i < 58; i++) if (b[i]) acc = acc ^ (q << i);
    return acc;
  endfunction

  function automatic logic [57:0] rand_divisor();
    logic [63:0] w;
    int dg;
    w  = {$urandom, $urandom};
    dg = $urandom_range(0, 57);
    if ($urandom_range(0, 19) == 0) return '0;
    w = w & ((64'd1 << dg) - 64'd1);
    w[dg] = 1'b1;
    return w[57:0];
  endfunction

  function automatic logic [114:0] rand_dividend();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[114:0];
  endfunction

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("quotient", 128'(quotient), 128'(exp_q));
      check("remainder", 128'(remainder), 128'(exp_r));
      check("div_by_zero", 128'(div_by_zero), 128'(exp_dz));
      check("ready_while_valid", 128'(in_ready), 128'(0));
    end
  end

  task automatic do_op(input logic [114:0] a, input logic [57:0] b, input int hold,
                       output int lat);
    logic [114:0] mq, mr;
    logic         mdz;
    int           budget;
    budget = 0;
    while (!in_ready && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    check("in_ready_before_op", 128'(in_ready), 128'(1));
    ref_div(a, b, mq, mr, mdz);
    exp_q  = QEN ? mq : '0;
    exp_r  = mr;
    exp_dz = mdz;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(ref_latency(b)));
`ifdef GF2DIV_QUOTIENT_EN
    if (out_valid && b != '0)
      check("identity", 128'(clmul(quotient, b) ^ 115'(remainder)), 128'(a));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = rand_dividend();
      divisor  = rand_divisor();
      check("in_ready_held", 128'(in_ready), 128'(0));
      check("out_valid_held", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_after_hs", 128'(out_valid), 128'(0));
    check("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [114:0] mq, mr, x;
    logic [57:0]  b;
    logic         mdz;
    logic         seen;
    int           lat;

    #2;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_quotient", 128'(quotient), 128'(0));
    check("rst_remainder", 128'(remainder), 128'(0));
    check("rst_dz", 128'(div_by_zero), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed divisions.
    ref_div(115'h7, 58'h3, mq, mr, mdz);
    check("model_q_7_3", 128'(mq), 128'h2);
    check("model_r_7_3", 128'(mr), 128'h1);
    ref_div(115'h0600000000000003, (58'd1 << 57) | 58'd1, mq, mr, mdz);
    check("model_q_deg57", 128'(mq), 128'h3);
    check("model_r_deg57", 128'(mr), 128'h0);

    do_op(115'h7, 58'h3, 0, lat);
    check("lat_7_3", 128'(lat), 128'd171);
    check("lit_q_7_3", 128'(quotient), QEN ? 128'h2 : 128'h0);
    check("lit_r_7_3", 128'(remainder), 128'h1);

    do_op(115'h0600000000000003, (58'd1 << 57) | 58'd1, 0, lat);
    check("lat_deg57", 128'(lat), 128'd59);
    check("lit_q_deg57", 128'(quotient), QEN ? 128'h3 : 128'h0);
    check("lit_r_deg57", 128'(remainder), 128'h0);

    x = rand_dividend();
    do_op(x, 58'h1, 0, lat);
    check("lat_deg0", 128'(lat), 128'd173);
    check("lit_q_div1", 128'(quotient), QEN ? 128'(x) : 128'h0);
    check("lit_r_div1", 128'(remainder), 128'h0);

    do_op(115'h5, 58'h0, 0, lat);
    check("lat_dz", 128'(lat), 128'd2);
    check("lit_dz", 128'(div_by_zero), 128'h1);
    check("lit_q_dz", 128'(quotient), 128'h0);
    check("lit_r_dz", 128'(remainder), 128'h0);

    do_op(rand_dividend(), rand_divisor() | 58'h1, 10, lat);
    do_op(rand_dividend(), rand_divisor(), 0, lat);

    // Reset in the middle of a division.
    b = (58'd1 << 57) | ({$urandom, $urandom} & ((58'd1 << 57) - 58'd1));
    dividend = rand_dividend();
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_quotient", 128'(quotient), 128'(0));
    check("midrst_remainder", 128'(remainder), 128'(0));
    check("midrst_dz", 128'(div_by_zero), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_valid", 128'(seen), 128'(0));
    do_op(rand_dividend(), b, 0, lat);

    for (int n = 0; n < 200; n++) begin
      x = ($urandom_range(0, 15) == 0) ? 115'h0 : rand_dividend();
      do_op(x, rand_divisor(), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
